// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester round-robin data memory arbiter
//
// Purpose: arbitrates between a CPU (requester 0) and a loader/debug port
// (requester 1). One single-port memory sits behind the arbiter. A write
// takes 2 cycles (IDLE, ACCESS). A read takes 3 cycles (IDLE, ACCESS, RWAIT).
// The read result is registered and pulsed on rvalidN.
//
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   reqN/weN/addrN/wdataN      request from requester N (0 = CPU, 1 = loader)
//   gntN                       access of requester N is on the memory bus
//   rvalidN/rdataN             read completion pulse / held read data
//   mem_en/mem_we              memory strobe / write enable
//   mem_addr/mem_wdata         memory address / write data
//   mem_rdata                  memory read data, one cycle after a read strobe
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RWAIT} state_t;

  state_t state, state_nxt;
  logic   sel;     // latched requester index
  logic   lat_we;  // latched write flag
  logic   last;    // requester granted most recently
  logic   pick;    // requester that wins arbitration this cycle
  logic   any_req;

  assign any_req = req0 | req1;
  // On a tie the requester not granted last time wins; otherwise whoever asks.
  assign pick = (req0 & req1) ? ~last : req1;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = lat_we;
        gnt0      = ~sel;
        gnt1      = sel;
        state_nxt = lat_we ? IDLE : RWAIT;
      end
      RWAIT: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The address and write-data registers drive the memory bus directly.
  // They are loaded only when a request is latched, so they hold their
  // values outside ACCESS.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sel       <= 1'b0;
      lat_we    <= 1'b0;
      last      <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      if (state == IDLE && any_req) begin
        sel       <= pick;
        lat_we    <= pick ? we1 : we0;
        mem_addr  <= pick ? addr1 : addr0;
        mem_wdata <= pick ? wdata1 : wdata0;
      end
      if (state == ACCESS) last <= sel;
      if (state == RWAIT) begin
        if (sel) begin
          rdata1  <= mem_rdata;
          rvalid1 <= 1'b1;
        end else begin
          rdata0  <= mem_rdata;
          rvalid0 <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0] mem [256];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem_rdata = 8'h00;
    reset = 1'b0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    step(); step(); step();

    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_rvalid", {rvalid0, rvalid1}, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rdata", {rdata0, rdata1}, 0);

    reset = 1'b1;
    step();

    // CPU write 0x5C to 0x0A
    req0 = 1; we0 = 1; addr0 = 8'h0A; wdata0 = 8'h5C;
    step();
    req0 = 0;
    check("wr_gnt0", gnt0, 1);
    check("wr_gnt1", gnt1, 0);
    check("wr_mem_en", mem_en, 1);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_addr", mem_addr, 8'h0A);
    check("wr_mem_wdata", mem_wdata, 8'h5C);
    step();
    check("wr_idle_en", mem_en, 0);
    check("wr_idle_we", mem_we, 0);
    check("wr_hold_addr", mem_addr, 8'h0A);

    // Loader read of 0x0A
    req1 = 1; we1 = 0; addr1 = 8'h0A;
    step();
    req1 = 0;
    check("rd1_gnt1", gnt1, 1);
    check("rd1_gnt0", gnt0, 0);
    check("rd1_mem_we", mem_we, 0);
    check("rd1_mem_en", mem_en, 1);
    step();
    check("rd1_wait_rvalid1", rvalid1, 0);
    check("rd1_wait_en", mem_en, 0);
    step();
    check("rd1_rvalid1", rvalid1, 1);
    check("rd1_rdata1", rdata1, 8'h5C);
    check("rd1_rvalid0", rvalid0, 0);
    check("rd1_rdata0", rdata0, 8'h00);
    step();
    check("rd1_pulse_end", rvalid1, 0);
    check("rd1_hold", rdata1, 8'h5C);

    // Both request writes continuously: CPU first (loader granted last)
    req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 8'h3C;
    req1 = 1; we1 = 1; addr1 = 8'h20; wdata1 = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      step();
      check("rr_gnt0", gnt0, (i == 0 || i == 4) ? 1 : 0);
      check("rr_gnt1", gnt1, (i == 2 || i == 6) ? 1 : 0);
      check("rr_excl", gnt0 & gnt1, 0);
    end
    req0 = 0; req1 = 0;

    // Single loader request wins even though it was granted last;
    // req1 drops right after being latched.
    req1 = 1; we1 = 1; addr1 = 8'h33; wdata1 = 8'h77;
    step();
    req1 = 0;
    check("drop_gnt1", gnt1, 1);
    check("drop_mem_en", mem_en, 1);
    check("drop_mem_addr", mem_addr, 8'h33);
    check("drop_mem_wdata", mem_wdata, 8'h77);
    step();

    // CPU read of 0x20 (written by loader with 0xA5)
    req0 = 1; we0 = 0; addr0 = 8'h20;
    step();
    req0 = 0;
    check("rd0_gnt0", gnt0, 1);
    step();
    step();
    check("rd0_rvalid0", rvalid0, 1);
    check("rd0_rdata0", rdata0, 8'hA5);
    check("rd0_rvalid1", rvalid1, 0);
    check("rd0_rdata1", rdata1, 8'h5C);
    step();

    // Reset during RWAIT of a CPU read
    req0 = 1; we0 = 0; addr0 = 8'h10;
    step();
    req0 = 0;
    check("rr2_gnt0", gnt0, 1);
    step();
    reset = 1'b0;
    step();
    check("mid_rvalid0", rvalid0, 0);
    check("mid_gnt", {gnt0, gnt1}, 0);
    check("mid_mem_en", mem_en, 0);
    check("mid_mem_addr", mem_addr, 0);
    check("mid_rdata", {rdata0, rdata1}, 0);
    reset = 1'b1;
    req0 = 1; we0 = 1; addr0 = 8'h01; wdata0 = 8'h11;
    req1 = 1; we1 = 1; addr1 = 8'h02; wdata1 = 8'h22;
    step();
    req0 = 0; req1 = 0;
    check("post_tie_gnt0", gnt0, 1);
    check("post_tie_gnt1", gnt1, 0);
    step();
    check("post_rvalid0", rvalid0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 8, address width; DATA_W, default 8, data width.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-004 reqN  in  1  access request from requester N (N=0 CPU, N=1 loader/debug).
REQ-005 weN  in  1  1 = write, 0 = read, for requester N.
REQ-006 addrN  in  ADDR_W  access address, requester N.
REQ-007 wdataN  in  DATA_W  write data, requester N.
REQ-008 gntN  out  1  one-cycle pulse: requester N's access is being issued to memory.
REQ-009 rvalidN  out  1  one-cycle pulse: rdataN holds read result for requester N.
REQ-010 rdataN  out  DATA_W  registered read data for requester N, held until its next read completes.
REQ-011 mem_en  out  1  memory access strobe.
REQ-012 mem_we  out  1  memory write enable, qualified by mem_en.
REQ-013 mem_addr  out  ADDR_W  memory address.
REQ-014 mem_wdata  out  DATA_W  memory write data.
REQ-015 mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0.

Function
REQ-016 FSM SHALL have three states: IDLE, ACCESS, RWAIT.
REQ-017 IDLE: if no reqN high, stay IDLE; else select one requester, latch its we/addr/wdata and index, go ACCESS.
REQ-018 Selection SHALL be round-robin: single requester wins; both high -> requester not granted last wins.
REQ-019 ACCESS: mem_en=1, mem_we/mem_addr/mem_wdata from latched request, gntN=1 for selected N; next state IDLE if write, RWAIT if read.
REQ-020 RWAIT: capture mem_rdata into rdataN of latched requester, assert rvalidN next cycle for exactly one cycle, go IDLE.
REQ-021 Latency from req sampled high in IDLE (cycle T): gnt at T+1; write lands at T+1; rvalid with data at T+3.
REQ-022 Throughput: back-to-back writes one per 2 cycles; back-to-back reads one per 3 cycles.
REQ-023 Requester SHALL hold req/we/addr/wdata stable until gnt; inputs outside IDLE sample cycle are ignored.
REQ-024 Once latched, a transaction SHALL complete even if req drops before gnt.
REQ-025 Outside ACCESS: mem_en=0, mem_we=0; mem_addr/mem_wdata hold last values.
REQ-026 gnt0 and gnt1 SHALL never both be 1; rvalid0 and rvalid1 SHALL never both be 1.
REQ-027 rdataN of the non-selected requester SHALL never change.
REQ-028 last-grant pointer SHALL update only in the cycle gnt is asserted.
REQ-029 Widths SHALL follow ADDR_W/DATA_W with no truncation or extension.

Reset
REQ-030 While reset=0 at rising clk: state IDLE, gnt0/gnt1/rvalid0/rvalid1/mem_en/mem_we=0, mem_addr/mem_wdata/rdata0/rdata1=0, last-grant=1 (CPU wins first tie).
REQ-031 Reset mid-transaction SHALL abandon it: no gnt, no rvalid, no mem_en in the cycle after reset is sampled low.
REQ-032 First arbitration SHALL occur in the first IDLE cycle with reset=1.

Verification
REQ-033 CPU write only: req0=1, we0=1, addr0=0x0A, wdata0=0x5C at T -> gnt0, mem_en=1, mem_we=1, mem_addr=0x0A, mem_wdata=0x5C at T+1; gnt1 stays 0.
REQ-034 Loader read of 0x0A (memory holds 0x5C) -> gnt1 at T+1, mem_we=0, rvalid1=1 with rdata1=0x5C at T+3; rdata0 unchanged.
REQ-035 Both request continuously after reset -> grants alternate gnt0, gnt1, gnt0, gnt1; never simultaneous.
REQ-036 req1 dropped in cycle after latch (before gnt) -> gnt1 and access still issued at T+1.
REQ-037 reset=0 asserted during RWAIT of a CPU read -> rvalid0 never pulses, all outputs zero next cycle, first post-reset tie goes to CPU.
